// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing one execution-unit result per cycle onto the common data bus.
// Optional conflict counter under CDB_CONFLICT_STATS_EN; 1-cycle latency, no downstream backpressure.
package cdb_arbiter_pkg;
   typedef struct packed {
      logic lt;
      logic gt;
      logic eq;
      logic so;
      logic ov;
      logic ca;
   } cond_exception_t;
endpackage

module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int UNITS       = 4,
   parameter int RS_ID_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [0:UNITS-1]        unit_valid,
   output logic [0:UNITS-1]        unit_ready,
   input  logic [0:RS_ID_WIDTH-1]  unit_rs_id    [0:UNITS-1],
   input  logic [0:4]              unit_reg_addr [0:UNITS-1],
   input  logic [0:31]             unit_result   [0:UNITS-1],
   input  cond_exception_t         unit_cr0_xer  [0:UNITS-1],
   output logic                    update_op_valid,
   output logic [0:RS_ID_WIDTH-1]  update_op_rs_id,
   output logic [0:31]             update_op_value,
   output logic                    gpr_we,
   output logic [0:4]              gpr_addr,
   output cond_exception_t         cr0_xer_out
`ifdef CDB_CONFLICT_STATS_EN
   ,
   output logic [0:15]             conflict_count
`endif
);

   localparam int PTR_W = $clog2(UNITS);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant;
   logic             grant_vld;

   // Search begins just after the last winner, so the previous grantee has lowest priority.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = 1; k <= UNITS; k++) begin
         if (!grant_vld && unit_valid[(int'(rr_ptr) + k) % UNITS]) begin
            grant_vld = 1'b1;
            grant     = PTR_W'((int'(rr_ptr) + k) % UNITS);
         end
      end
   end

   always_comb begin
      unit_ready = '0;
      if (rst && grant_vld) begin
         unit_ready[grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         update_op_valid <= 1'b0;
         gpr_we          <= 1'b0;
         update_op_rs_id <= '0;
         update_op_value <= '0;
         gpr_addr        <= '0;
         cr0_xer_out     <= '0;
         rr_ptr          <= PTR_W'(UNITS - 1);
      end else begin
         update_op_valid <= grant_vld;
         gpr_we          <= grant_vld;
         if (grant_vld) begin
            update_op_rs_id <= unit_rs_id[grant];
            update_op_value <= unit_result[grant];
            gpr_addr        <= unit_reg_addr[grant];
            cr0_xer_out     <= unit_cr0_xer[grant];
            rr_ptr          <= grant;
         end
      end
   end

`ifdef CDB_CONFLICT_STATS_EN
   // Counts cycles where more than one unit competes; sticks at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflict_count <= '0;
      end else if ($countones(unit_valid) > 1 && conflict_count != 16'hFFFF) begin
         conflict_count <= conflict_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts, a monitor pops and compares.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [0:3]      unit_valid = '0;
   logic [0:3]      unit_ready;
   logic [0:4]      unit_rs_id    [0:3];
   logic [0:4]      unit_reg_addr [0:3];
   logic [0:31]     unit_result   [0:3];
   cond_exception_t unit_cr0_xer  [0:3];
   logic            update_op_valid;
   logic [0:4]      update_op_rs_id;
   logic [0:31]     update_op_value;
   logic            gpr_we;
   logic [0:4]      gpr_addr;
   cond_exception_t cr0_xer_out;
`ifdef CDB_CONFLICT_STATS_EN
   logic [0:15]     conflict_count;
`endif

   typedef struct {
      logic            vld;
      logic [0:4]      rs;
      logic [0:31]     val;
      logic [0:4]      addr;
      cond_exception_t cr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   cdb_arbiter #(.UNITS(4), .RS_ID_WIDTH(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .unit_valid      (unit_valid),
      .unit_ready      (unit_ready),
      .unit_rs_id      (unit_rs_id),
      .unit_reg_addr   (unit_reg_addr),
      .unit_result     (unit_result),
      .unit_cr0_xer    (unit_cr0_xer),
      .update_op_valid (update_op_valid),
      .update_op_rs_id (update_op_rs_id),
      .update_op_value (update_op_value),
      .gpr_we          (gpr_we),
      .gpr_addr        (gpr_addr),
      .cr0_xer_out     (cr0_xer_out)
`ifdef CDB_CONFLICT_STATS_EN
      ,
      .conflict_count  (conflict_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Distinct payload per unit and per cycle so a wrong grant shows up as a data mismatch.
   task automatic fill();
      for (int u = 0; u < 4; u++) begin
         unit_rs_id[u]    = 5'((u * 8 + cyc) % 32);
         unit_reg_addr[u] = 5'((u * 5 + cyc) % 32);
         unit_result[u]   = 32'hC0DE0000 + 32'(u * 256 + cyc);
         unit_cr0_xer[u]  = cond_exception_t'(6'((u * 11 + cyc) % 64));
      end
      cyc++;
   endtask

   task automatic check_push(input int g);
      logic [0:3] er;
      exp_t       e;
      #1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      checks++;
      if (unit_ready !== er) begin
         errors++;
         $display("FAIL ready cyc=%0d: got %b want %b", cyc, unit_ready, er);
      end
      e.vld  = (g >= 0);
      e.rs   = '0;
      e.val  = '0;
      e.addr = '0;
      e.cr   = '0;
      if (g >= 0) begin
         e.rs   = unit_rs_id[g];
         e.val  = unit_result[g];
         e.addr = unit_reg_addr[g];
         e.cr   = unit_cr0_xer[g];
      end
      q.push_back(e);
   endtask

   task automatic step(input logic [0:3] v, input int g);
      @(negedge clk);
      fill();
      unit_valid = v;
      check_push(g);
   endtask

   task automatic check_val(input string name, input logic [0:63] got, input logic [0:63] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Monitor: each broadcast slot is compared against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         checks++;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (update_op_valid !== e.vld || gpr_we !== e.vld) begin
               errors++;
               $display("FAIL bcast_valid: valid=%b we=%b want %b", update_op_valid, gpr_we, e.vld);
            end else if (e.vld && {update_op_rs_id, update_op_value, gpr_addr, cr0_xer_out} !==
                                  {e.rs, e.val, e.addr, e.cr}) begin
               errors++;
               $display("FAIL bcast_data: rs=%0d val=%h addr=%0d cr=%b want rs=%0d val=%h addr=%0d cr=%b",
                        update_op_rs_id, update_op_value, gpr_addr, cr0_xer_out,
                        e.rs, e.val, e.addr, e.cr);
            end
         end else if (update_op_valid !== 1'b0) begin
            errors++;
            $display("FAIL bcast_unexpected: valid=%b val=%h", update_op_valid, update_op_value);
         end
      end
   end

   initial begin
      fill();
      unit_valid = 4'b1111;
      repeat (2) @(negedge clk);
      check_val("reset_ready", 64'(unit_ready), 64'h0);
      check_val("reset_valid", 64'({update_op_valid, gpr_we}), 64'h0);
      check_val("reset_rs_id", 64'(update_op_rs_id), 64'h0);
      check_val("reset_value", 64'(update_op_value), 64'h0);
      check_val("reset_addr_cr", 64'({gpr_addr, cr0_xer_out}), 64'h0);

      // Release with all four requesting: rotation starts at unit 0.
      @(negedge clk);
      rst = 1'b1;
      fill();
      unit_valid = 4'b1111;
      check_push(0);
      step(4'b1111, 1);
      step(4'b1111, 2);
      step(4'b1111, 3);
      step(4'b1111, 0);
      step(4'b1111, 1);
      step(4'b1111, 2);
      step(4'b1111, 3);
      step(4'b0000, -1);

      // Single requester with the documented payload.
      @(negedge clk);
      fill();
      unit_rs_id[2]    = 5'd9;
      unit_result[2]   = 32'hDEADBEEF;
      unit_reg_addr[2] = 5'd7;
      unit_valid       = 4'b0010;
      check_push(2);
      step(4'b0000, -1);

      // Pointer at 3, units 0 and 3 contend: wrap to 0, then 3.
      step(4'b0001, 3);
      step(4'b1001, 0);
      step(4'b1001, 3);
      step(4'b1001, 0);
      step(4'b0010, 2);
      step(4'b0010, 2);
      step(4'b1010, 0);
      step(4'b1010, 2);

      // Destination GPR0 is still broadcast.
      @(negedge clk);
      fill();
      unit_reg_addr[1] = 5'd0;
      unit_valid       = 4'b0100;
      check_push(1);
      step(4'b1000, 0);

      // Reset lands while a broadcast is on the bus and another request is pending.
      @(negedge clk);
      fill();
      unit_result[1] = 32'h12345678;
      unit_valid     = 4'b0100;
      rst            = 1'b0;
      #1;
      check_val("async_drop_valid", 64'({update_op_valid, gpr_we}), 64'h0);
      check_val("async_drop_value", 64'(update_op_value), 64'h0);
      check_push(-1);
      @(negedge clk);
      fill();
      unit_valid = 4'b0000;
      check_push(-1);
      rst = 1'b1;
      step(4'b1001, 0);
      step(4'b1001, 3);
      step(4'b0000, -1);

      // Fresh reset, then 10 contended cycles and 5 uncontended ones.
      @(negedge clk);
      unit_valid = 4'b0000;
      rst        = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) step(4'b1100, i % 2);
      for (int i = 0; i < 5; i++) step(4'b0010, 2);
      step(4'b0000, -1);

      repeat (3) @(negedge clk);
`ifdef CDB_CONFLICT_STATS_EN
      check_val("conflict_count", 64'(conflict_count), 64'd10);
`endif
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the execution-unit result interface: output_valid/ready, rs_id_out, result_reg_addr_out, result, cr0_xer.
- Arbitrates up to UNITS execution wrappers onto one common data bus (CDB).
- Each cycle, at most one result is broadcast on the update_op interface to all reservation stations, and written to the GPR file / CR0-XER logic.
- Sits between all *_wrapper result ports and the RS update ports and register file.

Parameters:
UNITS, 4, number of execution-unit result ports (2..8)
RS_ID_WIDTH, 5, width of reservation-station IDs

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
unit_valid  input  [0:UNITS-1]  per-unit result valid
unit_ready  output  [0:UNITS-1]  per-unit grant/ready
unit_rs_id  input  UNITS x [0:RS_ID_WIDTH-1]  producing RS ID per unit
unit_reg_addr  input  UNITS x [0:4]  destination GPR per unit
unit_result  input  UNITS x [0:31]  result value per unit
unit_cr0_xer  input  UNITS x cond_exception_t  condition/exception flags per unit
update_op_valid  output  1  CDB broadcast valid
update_op_rs_id  output  [0:RS_ID_WIDTH-1]  broadcast RS ID
update_op_value  output  [0:31]  broadcast value
gpr_we  output  1  GPR write enable (equals update_op_valid)
gpr_addr  output  [0:4]  GPR write address
cr0_xer_out  output  cond_exception_t  flags of broadcast result

Behaviour:
- Reset (rst=0, async): update_op_valid=0, gpr_we=0, update_op_rs_id=0, update_op_value=0, gpr_addr=0, cr0_xer_out=all zero, rr_ptr=UNITS-1. unit_ready is combinational and is 0 while rst=0.
- Arbitration is combinational round-robin over unit_valid. Search starts at index (rr_ptr+1) mod UNITS and wraps. The first valid index found is the grant g.
- unit_ready[g]=1 only for the granted unit. All other ready bits are 0. With no valid unit, all ready bits are 0.
- unit_ready never depends on a downstream ready. The CDB has no backpressure, so one result is accepted every cycle.
- Handshake: unit_valid[g] & unit_ready[g] at edge N transfers the result.
  - At edge N the output register loads: rs_id, value, reg_addr, cr0_xer of g, and update_op_valid=1, gpr_we=1.
  - Latency is exactly 1 cycle from handshake to broadcast.
  - rr_ptr <= g at the same edge.
- No handshake at edge N: update_op_valid and gpr_we become 0 at that edge. Data registers hold their last value. rr_ptr holds.
- Units must hold valid and payload stable until ready. The arbiter never grants a unit whose valid is low.
- Fairness: with all UNITS valid continuously, grants rotate 0,1,..,UNITS-1,0. Each unit waits at most UNITS-1 cycles.
- Wrap-around: if rr_ptr=UNITS-1, the search starts at 0.
- Simultaneous events:
  - A newly granted unit and the broadcast of the previous grant occur in the same cycle. This is legal; the pipeline is full-throughput.
  - A unit may be granted in back-to-back cycles if it is the only valid unit.
- Reset mid-operation: the in-flight broadcast is dropped (update_op_valid forced to 0). A unit holding valid is re-arbitrated after reset release, starting from unit 0.
- Writes with gpr_addr=0 are still broadcast. GPR0 handling belongs to the register file.

Optional Feature:
CDB_CONFLICT_STATS_EN
- Defined:
  - Adds output conflict_count [0:15].
  - Resets to 0 and increments by 1 on every cycle where two or more unit_valid bits are 1.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with unit_valid=4'b1111 held -> unit_ready=0 during reset. After release, the first grant is unit 0 and update_op_valid rises one cycle after.
- Single unit 2 valid with rs_id=5'd9, value=32'hDEADBEEF, reg_addr=5'd7 -> ready[2]=1 that cycle. Next cycle: update_op_valid=1, update_op_rs_id=9, update_op_value=DEADBEEF, gpr_addr=7. Following cycle: valid=0.
- All four units valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. update_op_valid is high for 8 consecutive cycles, each with the matching unit's payload.
- rr_ptr=3, units 0 and 3 valid -> unit 0 granted (wrap), then unit 3 next cycle.
- Assert rst during a cycle with a pending broadcast of value 32'h12345678 -> update_op_valid=0 immediately (async). That value never appears on the bus.
- With CDB_CONFLICT_STATS_EN: 10 cycles with two units valid, then 5 cycles with one unit valid -> conflict_count=10.
